// File: rtl/wb_route_1to2.sv
// One-to-two router: each input word is steered by S into a one-entry holding register per port.
// Illegal selects (2, 3) are accepted and discarded, and recorded in a sticky flag and a saturating counter.
module wb_route_1to2 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic [1:0]       S,
    input  logic             I_VALID,
    output logic             I_READY,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic             O0_VALID,
    output logic             O1_VALID,
    input  logic             O0_READY,
    input  logic             O1_READY,
    output logic             ERR,
    output logic [CNTW-1:0]  ERR_CNT,
    input  logic             ERR_CLR
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } port_state_e;

    port_state_e      st0_q, st0_d, st1_q, st1_d;
    logic [WIDTH-1:0] o0_q, o0_d, o1_q, o1_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             in_xfer;

    // A port can take a new word if it is empty or is being drained this same cycle.
    always_comb begin
        I_READY = 1'b1;
        case (S)
            2'd0:    I_READY = (st0_q == EMPTY) || O0_READY;
            2'd1:    I_READY = (st1_q == EMPTY) || O1_READY;
            default: I_READY = 1'b1;
        endcase
    end

    always_comb begin
        st0_d   = st0_q;
        st1_d   = st1_q;
        o0_d    = o0_q;
        o1_d    = o1_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        in_xfer = I_VALID && I_READY;

        if (st0_q == FULL && O0_READY) st0_d = EMPTY;
        if (st1_q == FULL && O1_READY) st1_d = EMPTY;

        // A new word overrides a simultaneous drain, so the port stays full.
        if (in_xfer) begin
            case (S)
                2'd0: begin
                    st0_d = FULL;
                    o0_d  = I;
                end
                2'd1: begin
                    st1_d = FULL;
                    o1_d  = I;
                end
                default: begin
                    err_d = 1'b1;
                    if (cnt_q != {CNTW{1'b1}}) cnt_d = cnt_q + CNTW'(1);
                end
            endcase
        end

        if (ERR_CLR) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st0_q <= EMPTY;
            st1_q <= EMPTY;
            o0_q  <= '0;
            o1_q  <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            st0_q <= st0_d;
            st1_q <= st1_d;
            o0_q  <= o0_d;
            o1_q  <= o1_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign O0       = o0_q;
    assign O1       = o1_q;
    assign O0_VALID = (st0_q == FULL);
    assign O1_VALID = (st1_q == FULL);
    assign ERR      = err_q;
    assign ERR_CNT  = cnt_q;

endmodule

// File: tb/tb_wb_route_1to2.sv
// Bench for wb_route_1to2: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the two holding registers and the error counter.
module tb_wb_route_1to2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] I;
    logic [1:0]  S;
    logic        I_VALID;
    logic        I_READY;
    logic [15:0] O0, O1;
    logic        O0_VALID, O1_VALID;
    logic        O0_READY, O1_READY;
    logic        ERR;
    logic [7:0]  ERR_CNT;
    logic        ERR_CLR;

    int checks = 0;
    int errors = 0;

    // Reference model: one slot per port plus error state.
    bit          m_v[2];
    logic [15:0] m_d[2];
    bit          m_err;
    int          m_cnt;

    wb_route_1to2 #(.WIDTH(16), .CNTW(8)) dut (
        .CLK(CLK), .RST(RST), .I(I), .S(S), .I_VALID(I_VALID), .I_READY(I_READY),
        .O0(O0), .O1(O1), .O0_VALID(O0_VALID), .O1_VALID(O1_VALID),
        .O0_READY(O0_READY), .O1_READY(O1_READY),
        .ERR(ERR), .ERR_CNT(ERR_CNT), .ERR_CLR(ERR_CLR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        if (S == 2'd0) return !m_v[0] || O0_READY;
        if (S == 2'd1) return !m_v[1] || O1_READY;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_v[0] = 0; m_v[1] = 0;
        m_d[0] = '0; m_d[1] = '0;
        m_err = 0; m_cnt = 0;
    endtask

    task automatic chk_outputs();
        chk("o0_valid", 32'(O0_VALID), 32'(m_v[0]));
        chk("o1_valid", 32'(O1_VALID), 32'(m_v[1]));
        if (m_v[0]) chk("o0_data", 32'(O0), 32'(m_d[0]));
        if (m_v[1]) chk("o1_data", 32'(O1), 32'(m_d[1]));
        chk("err", 32'(ERR), 32'(m_err));
        chk("err_cnt", 32'(ERR_CNT), 32'(m_cnt));
    endtask

    // Called just after a falling edge with inputs already driven; returns just after the next falling edge.
    task automatic cycle();
        bit          acc;
        bit          dr0, dr1, clr;
        logic [1:0]  sel;
        logic [15:0] dat;
        #1;
        chk("i_ready", 32'(I_READY), 32'(exp_ready()));
        acc = I_VALID && exp_ready();
        sel = S; dat = I; clr = ERR_CLR;
        dr0 = m_v[0] && O0_READY;
        dr1 = m_v[1] && O1_READY;
        @(posedge CLK);
        if (dr0) m_v[0] = 0;
        if (dr1) m_v[1] = 0;
        if (acc) begin
            if (sel < 2) begin
                m_v[sel[0]] = 1;
                m_d[sel[0]] = dat;
            end else begin
                m_err = 1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        if (clr) begin
            m_err = 0;
            m_cnt = 0;
        end
        #1;
        chk_outputs();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        I = '0; S = 2'd0; I_VALID = 0; O0_READY = 0; O1_READY = 0; ERR_CLR = 0;
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        model_reset();
        #1;
        chk("reset_o0_valid", 32'(O0_VALID), 32'd0);
        chk("reset_o1_valid", 32'(O1_VALID), 32'd0);
        chk("reset_o0", 32'(O0), 32'd0);
        chk("reset_err_cnt", 32'(ERR_CNT), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        S = 2'd1; #1;
        chk("ready_after_reset_s1", 32'(I_READY), 32'd1);
        S = 2'd0; #1;
        chk("ready_after_reset_s0", 32'(I_READY), 32'd1);
        @(negedge CLK);

        // Single word to port 0, held while not consumed.
        I = 16'hA5A5; S = 2'd0; I_VALID = 1;
        cycle();
        chk("req031_o0", 32'(O0), 32'h0000A5A5);
        I_VALID = 0; I = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("req031_hold", 32'(O0), 32'h0000A5A5);
            chk("req031_o1_valid", 32'(O1_VALID), 32'd0);
        end

        // Back-pressure, then drain and reload on the same edge.
        I = 16'h1234; S = 2'd0; I_VALID = 1; #1;
        chk("req032_ready_low", 32'(I_READY), 32'd0);
        cycle();
        chk("req032_o0_unchanged", 32'(O0), 32'h0000A5A5);
        O0_READY = 1;
        cycle();
        chk("req032_reload", 32'(O0), 32'h00001234);
        chk("req032_valid", 32'(O0_VALID), 32'd1);
        idle_inputs(); O0_READY = 1;
        cycle();

        // Alternating stream at full rate.
        O0_READY = 1; O1_READY = 1; I_VALID = 1;
        for (int k = 1; k <= 8; k++) begin
            I = 16'(k); S = (k % 2 == 1) ? 2'd0 : 2'd1; #1;
            chk("req033_ready", 32'(I_READY), 32'd1);
            cycle();
            if (k % 2 == 1) chk("req033_o0", 32'(O0), 32'(k));
            else            chk("req033_o1", 32'(O1), 32'(k));
        end
        idle_inputs(); O0_READY = 1; O1_READY = 1;
        cycle();

        // Illegal selects, saturation, and clear winning over a coincident illegal transfer.
        idle_inputs();
        I = 16'hFFFF; S = 2'd2; I_VALID = 1;
        cycle();
        S = 2'd3;
        cycle();
        chk("req034_err", 32'(ERR), 32'd1);
        chk("req034_cnt2", 32'(ERR_CNT), 32'd2);
        chk("req034_no_valid", 32'({O0_VALID, O1_VALID}), 32'd0);
        for (int k = 0; k < 300; k++) begin
            S = 2'(2 + (k % 2));
            cycle();
        end
        chk("req034_saturate", 32'(ERR_CNT), 32'd255);
        ERR_CLR = 1;
        cycle();
        chk("req034_clr_err", 32'(ERR), 32'd0);
        chk("req034_clr_cnt", 32'(ERR_CNT), 32'd0);
        idle_inputs();

        // Asynchronous reset with both ports full.
        I = 16'hBEEF; S = 2'd0; I_VALID = 1;
        cycle();
        I = 16'hCAFE; S = 2'd1;
        cycle();
        idle_inputs();
        chk("req035_both_full", 32'({O0_VALID, O1_VALID}), 32'd3);
        #2 RST = 1'b1;
        #1;
        model_reset();
        chk("req035_o0_valid", 32'(O0_VALID), 32'd0);
        chk("req035_o1_valid", 32'(O1_VALID), 32'd0);
        chk("req035_o0", 32'(O0), 32'd0);
        chk("req035_o1", 32'(O1), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        I = 16'h0042; S = 2'd1; I_VALID = 1;
        cycle();
        chk("req035_o1_new", 32'(O1), 32'h00000042);
        chk("req035_o0_stays_empty", 32'(O0_VALID), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            I        = 16'($urandom);
            S        = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            I_VALID  = 1'($urandom_range(0, 3) != 0);
            O0_READY = 1'($urandom_range(0, 2) != 0);
            O1_READY = 1'($urandom_range(0, 2) != 0);
            ERR_CLR  = 1'($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
